// File: rtl/mem_responder.sv
// mem_responder: memory-side responder with separate instruction and data word banks behind a request/response handshake.
// Latency: a request accepted at edge N raises rsp_valid for one cycle, entered at edge N+LATENCY (LATENCY wait states).
// Backpressure: req_ready drops from accept until the response cycle ends; the response itself cannot be stalled.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; accepted when valid & ready & (read | write)
//   i_ou_d                bank select (1 = instruction bank, 0 = data bank)
//   read, write           operation; both high gives an error response with no bank access
//   add                   byte address; word index = add[ADDR_W+1:2], upper bits alias
//   write_data            store data, captured at accept
//   rsp_valid             one-cycle response strobe
//   out, err              read data and error flag, meaningful only while rsp_valid = 1
//
// Optional feature: define MISALIGN_CHECK_EN to turn add[1:0] != 0 into an error
// response (no bank access, write suppressed). Without it add[1:0] is ignored.
module mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        i_ou_d,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] add,
    input  logic [31:0] write_data,
    output logic        rsp_valid,
    output logic [31:0] out,
    output logic        err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic       ZERO_LAT = (LATENCY == 0);
    // Counter is loaded with LATENCY-1 so WAIT lasts exactly LATENCY cycles.
    localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    // Bank storage: intentionally not reset.
    logic [31:0] mem_i [DEPTH];
    logic [31:0] mem_d [DEPTH];

    // FSM and captured-request state.
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              bank_q, bank_d;
    logic              mis_q, mis_d;
    logic [31:0]       out_q, out_d;
    logic              err_q, err_d;

    // Access operands for the edge that enters RESP.
    logic              accept;
    logic              enter_resp;
    logic              acc_from_inputs;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              acc_rd;
    logic              acc_wr;
    logic              acc_bank;
    logic              acc_mis;
    logic              acc_bad;
    logic [31:0]       rd_word;
    logic              mem_we;

    // Address bits that never select a word; misalignment bits are only
    // consumed when the check is compiled in.
    logic unused_add_bits;
    assign unused_add_bits = ^{add[31:ADDR_W+2], add[1:0]};

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign out       = out_q;
    assign err       = err_q;

    assign accept = req_valid & req_ready & (read | write);

    // With zero latency the bank access happens on the accept edge itself, so
    // the live request inputs are used; otherwise the captured copy is used.
    assign acc_from_inputs = (state_q == ST_IDLE);

    assign enter_resp = ((state_q == ST_IDLE) & accept & ZERO_LAT) |
                        ((state_q == ST_WAIT) & (cnt_q == 4'd0));

    always_comb begin
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_rd    = rd_q;
        acc_wr    = wr_q;
        acc_bank  = bank_q;
        acc_mis   = mis_q;
        if (acc_from_inputs) begin
            acc_idx   = add[ADDR_W+1:2];
            acc_wdata = write_data;
            acc_rd    = read;
            acc_wr    = write;
            acc_bank  = i_ou_d;
            acc_mis   = (add[1:0] != 2'b00);
        end
    end

`ifdef MISALIGN_CHECK_EN
    assign acc_bad = (acc_rd & acc_wr) | acc_mis;
`else
    assign acc_bad = acc_rd & acc_wr;
`endif

    assign rd_word = acc_bank ? mem_i[acc_idx] : mem_d[acc_idx];

    // rst_n gating keeps a write from committing on an edge seen during reset.
    assign mem_we = enter_resp & acc_wr & ~acc_bad & rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        bank_d  = bank_q;
        mis_d   = mis_q;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = add[ADDR_W+1:2];
                    wdata_d = write_data;
                    rd_d    = read;
                    wr_d    = write;
                    bank_d  = i_ou_d;
                    mis_d   = (add[1:0] != 2'b00);
                    if (ZERO_LAT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // Response lasts one cycle; clear the data so stale values
                // are not left on the bus.
                state_d = ST_IDLE;
                out_d   = 32'd0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            out_d = (acc_rd & ~acc_bad) ? rd_word : 32'd0;
            err_d = acc_bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            bank_q  <= 1'b0;
            mis_q   <= 1'b0;
            out_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            bank_q  <= bank_d;
            mis_q   <= mis_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Bank writes: the two banks are written independently, never both.
    always_ff @(posedge clk) begin
        if (mem_we & acc_bank) begin
            mem_i[acc_idx] <= acc_wdata;
        end
        if (mem_we & ~acc_bank) begin
            mem_d[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=2 main instance, LATENCY=0 side instance).
// Latency: expected responses carry their accept cycle; the monitor checks rsp_valid arrives LATENCY+1 cycles on.
// Backpressure: the driver waits for req_ready (bounded) before each request.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, i_ou_d, read, write;
    logic [31:0] add, write_data;
    logic        rsp_valid, err;
    logic [31:0] rsp_out;

    logic        z_req_valid, z_req_ready, z_i_ou_d, z_read, z_write;
    logic [31:0] z_add, z_write_data;
    logic        z_rsp_valid, z_err;
    logic [31:0] z_out;

    mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .i_ou_d(i_ou_d), .read(read), .write(write),
        .add(add), .write_data(write_data),
        .rsp_valid(rsp_valid), .out(rsp_out), .err(err)
    );

    mem_responder #(.ADDR_W(4), .LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .i_ou_d(z_i_ou_d), .read(z_read), .write(z_write),
        .add(z_add), .write_data(z_write_data),
        .rsp_valid(z_rsp_valid), .out(z_out), .err(z_err)
    );

    typedef struct {
        logic [31:0] out;
        logic        err;
        bit          chk_out;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_d[int];
    logic [31:0] m_i[int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    bit          rdy_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: ready must be low exactly while a tracked request is pending;
    // every response is popped and compared in order.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rdy_chk) check("req_ready_vs_pending", {31'b0, req_ready}, {31'b0, (sb.size() == 0)});
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with nothing pending (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("rsp_latency", 32'(cyc - e.acc), 32'(LAT + 1));
                    check("rsp_err", {31'b0, err}, {31'b0, e.err});
                    if (e.chk_out) check("rsp_out", rsp_out, e.out);
                end
            end
        end
    end

    // Drive one request; when track=1 the reference model is updated and the
    // expected response is queued for the monitor.
    task automatic issue(input bit bank, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input bit track);
        exp_t e;
        int   w;
        bit   bad;
        int   guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready stayed 0, expected 1");
            return;
        end
        w   = int'((a >> 2) & 32'(DEPTH - 1));
        bad = rd && wr;
`ifdef MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) bad = 1'b1;
`endif
        e.acc     = cyc;
        e.err     = bad;
        e.out     = 32'd0;
        e.chk_out = 1'b1;
        if (!bad && rd) begin
            if (bank) begin
                if (m_i.exists(w)) e.out = m_i[w]; else e.chk_out = 1'b0;
            end else begin
                if (m_d.exists(w)) e.out = m_d[w]; else e.chk_out = 1'b0;
            end
        end
        if (!bad && wr && track) begin
            if (bank) m_i[w] = d; else m_d[w] = d;
        end
        req_valid  = 1'b1;
        i_ou_d     = bank;
        read       = rd;
        write      = wr;
        add        = a;
        write_data = d;
        @(posedge clk);
        if ((rd || wr) && track) sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        // A request with neither read nor write must leave the responder idle.
        if (!(rd || wr)) check("noop_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb.size() != 0 || !req_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic z_req(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_out);
        @(negedge clk);
        check("lat0_ready_before", {31'b0, z_req_ready}, 32'd1);
        z_req_valid  = 1'b1;
        z_i_ou_d     = 1'b0;
        z_read       = rd;
        z_write      = wr;
        z_add        = a;
        z_write_data = d;
        @(posedge clk);
        @(negedge clk);
        z_req_valid = 1'b0;
        z_read      = 1'b0;
        z_write     = 1'b0;
        check("lat0_rsp_valid", {31'b0, z_rsp_valid}, 32'd1);
        check("lat0_ready_busy", {31'b0, z_req_ready}, 32'd0);
        check("lat0_err", {31'b0, z_err}, 32'd0);
        check("lat0_out", z_out, exp_out);
        @(negedge clk);
        check("lat0_rsp_done", {31'b0, z_rsp_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0; i_ou_d = 1'b0; read = 1'b0; write = 1'b0;
        add          = 32'd0; write_data = 32'd0;
        z_req_valid  = 1'b0; z_i_ou_d = 1'b0; z_read = 1'b0; z_write = 1'b0;
        z_add        = 32'd0; z_write_data = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_out", rsp_out, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        rst_n   = 1'b1;
        mon_en  = 1'b1;
        rdy_chk = 1'b1;

        // Write/read data bank, then an independent instruction-bank word.
        issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 1);
        issue(0, 1, 0, 32'h10, 32'h0, 1);
        issue(1, 0, 1, 32'h10, 32'h11111111, 1);
        issue(0, 1, 0, 32'h10, 32'h0, 1);
        issue(1, 1, 0, 32'h10, 32'h0, 1);
        // Address aliasing above ADDR_W+1.
        issue(0, 0, 1, 32'h1000, 32'hA5A5A5A5, 1);
        issue(0, 1, 0, 32'h0, 32'h0, 1);
        // read=write=1 is an error with no bank access; no-op request is ignored.
        issue(0, 1, 1, 32'h10, 32'hFFFFFFFF, 1);
        issue(0, 1, 0, 32'h10, 32'h0, 1);
        issue(0, 0, 0, 32'h10, 32'h0, 1);
        // Misaligned accesses (model follows the compiled-in behaviour).
        issue(0, 0, 1, 32'h13, 32'hCAFEF00D, 1);
        issue(0, 1, 0, 32'h10, 32'h0, 1);
        issue(0, 1, 0, 32'h13, 32'h0, 1);
        wait_idle();

        // Reset in the middle of a write must discard it.
        issue(0, 0, 1, 32'h20, 32'h0BADF00D, 1);
        wait_idle();
        rdy_chk = 1'b0;
        issue(0, 0, 1, 32'h20, 32'h12345678, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'b0, req_ready}, 32'd1);
        check("midrst_out", rsp_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        rdy_chk = 1'b1;
        repeat (3) @(negedge clk);
        issue(0, 1, 0, 32'h20, 32'h0, 1);
        wait_idle();

        // Randomized traffic over a small word set so reads hit earlier writes.
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 9));
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            case (op)
                0:             issue(1'($urandom), 0, 0, a, $urandom, 1);
                1:             issue(1'($urandom), 1, 1, a, $urandom, 1);
                2, 3, 4, 5:    issue(1'($urandom), 0, 1, a, $urandom, 1);
                default:       issue(1'($urandom), 1, 0, a, $urandom, 1);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // Zero-latency instance: response in the cycle right after accept,
        // ADDR_W=4 so 0x44 and 0x04 alias.
        z_req(0, 1, 32'h44, 32'h5555AAAA, 32'h0);
        z_req(1, 0, 32'h44, 32'h0, 32'h5555AAAA);
        z_req(1, 0, 32'h04, 32'h0, 32'h5555AAAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
